// File: rtl/onehot_decoder_ctrl.sv
// One-hot decoder controller: a request either pulses one output line for PULSE_LEN
// cycles or starts a free-running scan that dwells DWELL cycles per line until stopped.
module onehot_decoder_ctrl #(
    parameter int N_SEL     = 3,
    parameter int PULSE_LEN = 4,
    parameter int DWELL     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [N_SEL-1:0]      din_sel,
    input  logic                  din_mode,
    input  logic                  din_stop,
    output logic [(2**N_SEL)-1:0] dout,
    output logic                  dout_busy,
    output logic                  dout_wrap
);

    localparam int W    = 2**N_SEL;
    localparam int CMAX = (PULSE_LEN > DWELL) ? PULSE_LEN : DWELL;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0]    PULSE_LOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0]    DWELL_LOAD = CW'(DWELL - 1);
    localparam logic [CW-1:0]    CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
    localparam logic [N_SEL-1:0] IDX_ZERO   = N_SEL'(0);
    localparam logic [N_SEL-1:0] IDX_ONE    = N_SEL'(1);
    localparam logic [N_SEL-1:0] IDX_LAST   = {N_SEL{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_SCAN  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [N_SEL-1:0] idx_r, idx_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [W-1:0]     dout_r, dout_s;
    logic             wrap_r, wrap_s;
    logic             busy_r;
    logic             ready_s;
    logic             accept_s;

    function automatic logic [W-1:0] onehot(input logic [N_SEL-1:0] code);
        logic [W-1:0] v;
        v       = {W{1'b0}};
        v[code] = 1'b1;
        return v;
    endfunction

    assign ready_s   = (state_r == ST_IDLE) & ~din_stop;
    assign accept_s  = din_valid & ready_s;
    assign din_ready = ready_s;
    assign dout      = dout_r;
    assign dout_busy = busy_r;
    assign dout_wrap = wrap_r;

    // Next-state, index/counter and next output value; stop outranks expiry and wrap.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        dout_s  = {W{1'b0}};
        wrap_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    idx_s  = din_sel;
                    dout_s = onehot(din_sel);
                    if (din_mode) begin
                        state_s = ST_SCAN;
                        cnt_s   = DWELL_LOAD;
                    end else begin
                        state_s = ST_PULSE;
                        cnt_s   = PULSE_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (din_stop || (cnt_r == CNT_ZERO)) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s  = cnt_r - CNT_ONE;
                    dout_s = onehot(idx_r);
                end
            end
            ST_SCAN: begin
                if (din_stop) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_ZERO) begin
                    idx_s  = idx_r + IDX_ONE;
                    cnt_s  = DWELL_LOAD;
                    dout_s = onehot(idx_r + IDX_ONE);
                    wrap_s = (idx_r == IDX_LAST);
                end else begin
                    cnt_s  = cnt_r - CNT_ONE;
                    dout_s = onehot(idx_r);
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = IDX_ZERO;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= IDX_ZERO;
            cnt_r   <= CNT_ZERO;
            dout_r  <= {W{1'b0}};
            wrap_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            dout_r  <= dout_s;
            wrap_r  <= wrap_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_onehot_decoder_ctrl.sv
// Bench for onehot_decoder_ctrl: three parameterisations driven side by side and checked
// every cycle against a cycles-since-accept reference model.
module tb_onehot_decoder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  vld, mode, stp;
    logic [5:0]  sel [3];
    logic [2:0]  rdy, busy, wrp;
    logic [7:0]  d0;
    logic [1:0]  d1;
    logic [15:0] d2;

    int checks   = 0;
    int failures = 0;

    int NS [3] = '{3, 1, 4};
    int PL [3] = '{4, 1, 1};
    int DW [3] = '{2, 1, 1};

    // Model: whether an operation is live, its mode, start code, and cycles since accept.
    bit act [3];
    bit md  [3];
    int ms  [3];
    int k   [3];

    always #5 clk = ~clk;

    onehot_decoder_ctrl #(.N_SEL(3), .PULSE_LEN(4), .DWELL(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .din_valid(vld[0]), .din_ready(rdy[0]),
        .din_sel(sel[0][2:0]), .din_mode(mode[0]), .din_stop(stp[0]),
        .dout(d0), .dout_busy(busy[0]), .dout_wrap(wrp[0]));

    onehot_decoder_ctrl #(.N_SEL(1), .PULSE_LEN(1), .DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din_valid(vld[1]), .din_ready(rdy[1]),
        .din_sel(sel[1][0:0]), .din_mode(mode[1]), .din_stop(stp[1]),
        .dout(d1), .dout_busy(busy[1]), .dout_wrap(wrp[1]));

    onehot_decoder_ctrl #(.N_SEL(4), .PULSE_LEN(1), .DWELL(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .din_valid(vld[2]), .din_ready(rdy[2]),
        .din_sel(sel[2][3:0]), .din_mode(mode[2]), .din_stop(stp[2]),
        .dout(d2), .dout_busy(busy[2]), .dout_wrap(wrp[2]));

    function automatic logic [63:0] obs_dout(input int i);
        case (i)
            0:       return {56'd0, d0};
            1:       return {62'd0, d1};
            default: return {48'd0, d2};
        endcase
    endfunction

    function automatic int scan_pos(input int i);
        return (ms[i] + (k[i] - 1) / DW[i]) % (1 << NS[i]);
    endfunction

    function automatic logic [63:0] exp_dout(input int i);
        if (!act[i]) return 64'd0;
        if (!md[i])  return 64'd1 << ms[i];
        return 64'd1 << scan_pos(i);
    endfunction

    function automatic logic exp_wrap(input int i);
        return act[i] && md[i] && (k[i] > 1) && (((k[i] - 1) % DW[i]) == 0) && (scan_pos(i) == 0);
    endfunction

    task automatic chk(input string tag, input int i, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h at %0t", tag, i, o, e, $time);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 3; i++) begin
            chk("dout", i, obs_dout(i), exp_dout(i));
            chk("wrap", i, {63'd0, wrp[i]}, {63'd0, exp_wrap(i)});
            chk("busy", i, {63'd0, busy[i]}, {63'd0, act[i]});
            chk("onehot0", i, {63'd0, $onehot0(obs_dout(i))}, 64'd1);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            act[i] = 1'b0;
            k[i]   = 0;
        end
    endtask

    // One clock: check ready with current inputs, advance the model at the edge, check outputs.
    task automatic cycle();
        #1;
        for (int i = 0; i < 3; i++)
            chk("ready", i, {63'd0, rdy[i]}, {63'd0, (!act[i] && !stp[i])});
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (act[i] && stp[i]) act[i] = 1'b0;
            else if (act[i] && !md[i] && k[i] == PL[i]) act[i] = 1'b0;
            else if (act[i]) k[i]++;
            else if (vld[i] && !stp[i]) begin
                act[i] = 1'b1;
                md[i]  = mode[i];
                ms[i]  = int'(sel[i]) % (1 << NS[i]);
                k[i]   = 1;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic drive(input int i, input logic v, input int s, input logic m, input logic st);
        vld[i]  = v;
        sel[i]  = 6'(s);
        mode[i] = m;
        stp[i]  = st;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        #2 rst_n = 1'b1;

        // Single pulse of code 5 on the 8-output instance.
        drive(0, 1'b1, 5, 1'b0, 1'b0);
        cycle();
        chk("pulse5", 0, obs_dout(0), 64'h20);
        drive(0, 1'b0, 0, 1'b0, 1'b0);
        repeat (6) cycle();

        // Every code in pulse mode, back to back as soon as ready returns.
        for (int c = 0; c < 8; c++) begin
            drive(0, 1'b1, c, 1'b0, 1'b0);
            cycle();
            drive(0, 1'b0, 0, 1'b0, 1'b0);
            repeat (4) cycle();
        end

        // Scan from 6 through the wrap, then stop.
        drive(0, 1'b1, 6, 1'b1, 1'b0);
        cycle();
        drive(0, 1'b0, 0, 1'b0, 1'b0);
        repeat (4) cycle();
        chk("wrap_seen", 0, {63'd0, wrp[0]}, 64'd1);
        repeat (5) cycle();
        drive(0, 1'b0, 0, 1'b0, 1'b1);
        cycle();
        idle_all();
        cycle();

        // Stop on the cycle the index would wrap, with valid held high alongside stop.
        drive(0, 1'b1, 7, 1'b1, 1'b0);
        cycle();
        drive(0, 1'b0, 0, 1'b0, 1'b0);
        cycle();
        drive(0, 1'b1, 3, 1'b0, 1'b1);
        cycle();
        chk("stop_dout", 0, obs_dout(0), 64'd0);
        chk("stop_wrap", 0, {63'd0, wrp[0]}, 64'd0);
        cycle();
        chk("stop_noaccept", 0, {63'd0, busy[0]}, 64'd0);
        idle_all();
        cycle();

        // Minimal-parameter scans on the 2- and 16-output instances.
        drive(1, 1'b1, 1, 1'b1, 1'b0);
        drive(2, 1'b1, 0, 1'b1, 1'b0);
        cycle();
        idle_all();
        repeat (40) cycle();
        drive(1, 1'b0, 0, 1'b0, 1'b1);
        drive(2, 1'b0, 0, 1'b0, 1'b1);
        cycle();
        idle_all();

        // Single-cycle pulses accepted every other cycle.
        for (int r = 0; r < 6; r++) begin
            drive(1, 1'b1, r, 1'b0, 1'b0);
            drive(2, 1'b1, r * 3, 1'b0, 1'b0);
            cycle();
        end
        idle_all();
        cycle();

        // Asynchronous reset in the middle of a pulse.
        drive(0, 1'b1, 3, 1'b0, 1'b0);
        cycle();
        idle_all();
        cycle();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_dout", 0, obs_dout(0), 64'd0);
        chk("rst_busy", 0, {63'd0, busy[0]}, 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive(0, 1'b1, 2, 1'b0, 1'b0);
        cycle();
        idle_all();
        repeat (5) cycle();

        // Random traffic on all instances.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++)
                drive(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
